// File: rtl/avl_mem_responder_if.sv
// Avalon-MM memory port between the L2 cache (master) and its memory responder (slave).
interface avl_mem_responder_if #(
   parameter int AVL_ADDR       = 30,
   parameter int AVL_SIZE       = 3,
   parameter int AVL_DATA_WIDTH = 256,
   parameter int AVL_BE         = 32
);
   logic                      avl_ready;
   logic [AVL_ADDR-1:0]       avl_addr;
   logic [AVL_SIZE-1:0]       avl_size;
   logic [AVL_DATA_WIDTH-1:0] avl_wdata;
   logic [AVL_DATA_WIDTH-1:0] avl_rdata;
   logic                      avl_write_req;
   logic                      avl_read_req;
   logic                      avl_rdata_valid;
   logic [AVL_BE-1:0]         avl_be;
   logic                      avl_burstbegin;

   modport master (
      input  avl_ready, avl_rdata, avl_rdata_valid,
      output avl_addr, avl_size, avl_wdata, avl_write_req, avl_read_req, avl_be, avl_burstbegin
   );

   modport slave (
      output avl_ready, avl_rdata, avl_rdata_valid,
      input  avl_addr, avl_size, avl_wdata, avl_write_req, avl_read_req, avl_be, avl_burstbegin
   );
endinterface

// File: rtl/avl_mem_responder.sv
// On-chip stand-in for the DDR2 controller: byte-merged burst writes, fixed-latency read bursts.
// Write beats accepted with zero wait states; avl_ready drops for a read until its last beat is out.
module avl_mem_responder #(
   parameter int AVL_ADDR       = 30,
   parameter int AVL_SIZE       = 3,
   parameter int AVL_DATA_WIDTH = 256,
   parameter int AVL_BE         = 32,
   parameter int MEM_DEPTH_BITS = 10,
   parameter int READ_LATENCY   = 4
) (
   input  logic                clk,
   input  logic                reset,
   avl_mem_responder_if.slave  avl,
   output logic                proto_err
);
   typedef enum logic [1:0] {ST_IDLE, ST_WR_BURST, ST_RD_WAIT, ST_RD_BURST} state_t;

   localparam logic [3:0] LAT_LOAD = 4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   logic [AVL_DATA_WIDTH-1:0] r_mem [2**MEM_DEPTH_BITS];

   state_t                    r_state;
   logic [MEM_DEPTH_BITS-1:0] r_base;
   logic [AVL_SIZE-1:0]       r_len;
   logic [AVL_SIZE-1:0]       r_cnt;
   logic [3:0]                r_lat;
   logic                      r_ready;
   logic                      r_valid;
   logic [AVL_DATA_WIDTH-1:0] r_rdata;
   logic                      r_err;

   state_t                    w_state_nxt;
   logic [MEM_DEPTH_BITS-1:0] w_base_nxt;
   logic [AVL_SIZE-1:0]       w_len_nxt;
   logic [AVL_SIZE-1:0]       w_cnt_nxt;
   logic [3:0]                w_lat_nxt;
   logic                      w_err_nxt;
   logic                      w_we;
   logic                      w_rd_beat;
   logic [MEM_DEPTH_BITS-1:0] w_idx;
   logic [AVL_SIZE-1:0]       w_req_len;
   logic [AVL_SIZE-1:0]       w_cnt_inc;
   logic                      w_unused;

   assign w_unused  = &{1'b0, avl.avl_burstbegin, avl.avl_addr[AVL_ADDR-1:MEM_DEPTH_BITS]};
   assign w_req_len = (avl.avl_size == '0) ? AVL_SIZE'(1) : avl.avl_size;
   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_lat_nxt   = r_lat;
      w_err_nxt   = r_err;
      w_we        = 1'b0;
      w_rd_beat   = 1'b0;
      // Beat 0 of a new command addresses the RAM straight from the bus
      w_idx       = (r_state == ST_IDLE) ? avl.avl_addr[MEM_DEPTH_BITS-1:0]
                                         : r_base + MEM_DEPTH_BITS'(r_cnt);
      case (r_state)
         ST_IDLE: begin
            if (r_ready && avl.avl_write_req) begin
               w_we       = 1'b1;
               w_base_nxt = avl.avl_addr[MEM_DEPTH_BITS-1:0];
               w_len_nxt  = w_req_len;
               w_cnt_nxt  = AVL_SIZE'(1);
               if (w_req_len != AVL_SIZE'(1)) w_state_nxt = ST_WR_BURST;
               if (avl.avl_read_req) w_err_nxt = 1'b1;
            end else if (r_ready && avl.avl_read_req) begin
               w_base_nxt = avl.avl_addr[MEM_DEPTH_BITS-1:0];
               w_len_nxt  = w_req_len;
               if (READ_LATENCY == 1) begin
                  w_state_nxt = ST_RD_BURST;
                  w_rd_beat   = 1'b1;
                  w_cnt_nxt   = AVL_SIZE'(1);
               end else begin
                  w_state_nxt = ST_RD_WAIT;
                  w_cnt_nxt   = '0;
                  w_lat_nxt   = LAT_LOAD;
               end
            end
         end
         ST_WR_BURST: begin
            if (avl.avl_read_req) w_err_nxt = 1'b1;
            if (avl.avl_write_req) begin
               w_we      = 1'b1;
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_len) w_state_nxt = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (r_lat == 4'd0) begin
               w_state_nxt = ST_RD_BURST;
               w_rd_beat   = 1'b1;
               w_cnt_nxt   = w_cnt_inc;
            end else begin
               w_lat_nxt = r_lat - 4'd1;
            end
         end
         ST_RD_BURST: begin
            if (r_cnt == r_len) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_rd_beat = 1'b1;
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (reset) begin
         w_we      = 1'b0;
         w_rd_beat = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_lat   <= '0;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_base  <= w_base_nxt;
         r_len   <= w_len_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lat   <= w_lat_nxt;
         r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WR_BURST);
         r_valid <= w_rd_beat;
         r_err   <= w_err_nxt;
         if (w_rd_beat) r_rdata <= r_mem[w_idx];
      end
   end

   // RAM contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < AVL_BE; b++) begin
            if (avl.avl_be[b]) r_mem[w_idx][b*8 +: 8] <= avl.avl_wdata[b*8 +: 8];
         end
      end
   end

   assign avl.avl_ready       = r_ready;
   assign avl.avl_rdata_valid = r_valid;
   assign avl.avl_rdata       = r_rdata;
   assign proto_err           = r_err;
endmodule

// File: tb/tb_avl_mem_responder.sv
// Bench for avl_mem_responder: reference memory model, read-data scoreboard, byte-merge vector table.
module tb_avl_mem_responder;
   localparam int AW = 30, SW = 3, DW = 256, BW = 32, DB = 10, LAT = 4, DEPTH = 1024;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] init;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
      logic [DW-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic proto_err;

   avl_mem_responder_if #(.AVL_ADDR(AW), .AVL_SIZE(SW), .AVL_DATA_WIDTH(DW), .AVL_BE(BW)) bus ();

   avl_mem_responder #(
      .AVL_ADDR(AW), .AVL_SIZE(SW), .AVL_DATA_WIDTH(DW), .AVL_BE(BW),
      .MEM_DEPTH_BITS(DB), .READ_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .avl(bus), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            beats_seen = 0;
   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] sb_q [$];
   vec_t          vecs [5];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Every returned beat is matched against the next expected one
   always @(negedge clk) begin
      if (bus.avl_rdata_valid) begin
         beats_seen++;
         if (sb_q.size() == 0) chk("beat_without_expectation", DW'(bus.avl_rdata_valid), '0);
         else chk("rdata", bus.avl_rdata, sb_q.pop_front());
      end
   end

   task automatic push_model(input logic [AW-1:0] addr, input int len);
      for (int i = 0; i < len; i++) sb_q.push_back(model[addr[DB-1:0] + DB'(i)]);
   endtask

   task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [BW-1:0] be,
                              input int gap, input logic [DW-1:0] seed);
      logic [DB-1:0] idx;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 1) begin
            for (int g = 0; g < gap; g++) begin
               bus.avl_write_req  = 1'b0;
               bus.avl_burstbegin = 1'b0;
               chk("ready_in_wait_state", DW'(bus.avl_ready), 1);
               @(negedge clk);
            end
         end
         bus.avl_write_req  = 1'b1;
         bus.avl_addr       = addr;
         bus.avl_size       = SW'(len);
         bus.avl_burstbegin = (i == 0);
         bus.avl_wdata      = seed + DW'(i);
         bus.avl_be         = be;
         chk("ready_on_write_beat", DW'(bus.avl_ready), 1);
         idx = addr[DB-1:0] + DB'(i);
         for (int b = 0; b < BW; b++)
            if (be[b]) model[idx][b*8 +: 8] = bus.avl_wdata[b*8 +: 8];
      end
      @(negedge clk);
      bus.avl_write_req  = 1'b0;
      bus.avl_burstbegin = 1'b0;
      chk("ready_after_write", DW'(bus.avl_ready), 1);
   endtask

   task automatic read_burst(input logic [AW-1:0] addr, input int len);
      int k;
      int n;
      @(negedge clk);
      bus.avl_read_req = 1'b1;
      bus.avl_addr     = addr;
      bus.avl_size     = SW'(len);
      k = 0;
      while (!bus.avl_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("read_accept_ready", DW'(bus.avl_ready), 1);
      @(negedge clk);
      bus.avl_read_req = 1'b0;
      chk("ready_low_after_read_accept", DW'(bus.avl_ready), 0);
      k = 1;
      while (!bus.avl_rdata_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("first_beat_latency", DW'(k), DW'(LAT));
      n = 0;
      while (bus.avl_rdata_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("read_beat_count", DW'(n), DW'(len));
      chk("ready_after_read_burst", DW'(bus.avl_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] seed_d;
      logic [DW-1:0] seed_r;
      int            bs;

      vecs[0] = '{30'd7,  {32{8'hFF}}, {32{8'h00}}, 32'h0000000F, {{28{8'hFF}}, {4{8'h00}}}};
      vecs[1] = '{30'd8,  {32{8'h11}}, {32{8'h22}}, 32'hF0F0F0F0, {4{{4{8'h22}}, {4{8'h11}}}}};
      vecs[2] = '{30'd9,  {32{8'h33}}, {32{8'h44}}, 32'h00000000, {32{8'h33}}};
      vecs[3] = '{30'd10, {32{8'h55}}, {32{8'h66}}, 32'hFFFFFFFF, {32{8'h66}}};
      vecs[4] = '{30'd11, {32{8'h11}}, {32{8'h22}}, 32'h80000001, {8'h22, {30{8'h11}}, 8'h22}};

      bus.avl_addr = '0; bus.avl_size = '0; bus.avl_wdata = '0; bus.avl_be = '0;
      bus.avl_write_req = 1'b0; bus.avl_read_req = 1'b0; bus.avl_burstbegin = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_ready", DW'(bus.avl_ready), 0);
      chk("reset_valid", DW'(bus.avl_rdata_valid), 0);
      chk("reset_rdata", bus.avl_rdata, '0);
      chk("reset_proto_err", DW'(proto_err), 0);
      reset = 1'b0;
      chk("ready_before_release_sampled", DW'(bus.avl_ready), 0);
      @(negedge clk);
      chk("ready_first_cycle_after_release", DW'(bus.avl_ready), 1);

      // Single beat write then read
      write_burst(30'd5, 1, '1, 0, {32{8'hA5}});
      sb_q.push_back({32{8'hA5}});
      read_burst(30'd5, 1);

      // Burst wrapping the top of the RAM
      seed_d = {8{32'hD0D0_0000}};
      write_burst(30'd1022, 4, '1, 0, seed_d);
      push_model(30'd1022, 4);
      read_burst(30'd1022, 4);
      sb_q.push_back(seed_d + DW'(2));
      sb_q.push_back(seed_d + DW'(3));
      read_burst(30'd0, 2);
      sb_q.push_back(seed_d + DW'(2));
      read_burst(30'd1024, 1);

      // Byte-enable merge vectors
      for (int v = 0; v < 5; v++) begin
         write_burst(vecs[v].addr, 1, '1, 0, vecs[v].init);
         write_burst(vecs[v].addr, 1, vecs[v].be, 0, vecs[v].wdata);
         sb_q.push_back(vecs[v].exp);
         read_burst(vecs[v].addr, 1);
      end

      // Write burst with master wait states; beat at 103 must stay untouched
      write_burst(30'd100, 4, '1, 0, {8{32'h5000_0000}});
      write_burst(30'd100, 3, '1, 2, {8{32'h6000_0000}});
      push_model(30'd100, 4);
      read_burst(30'd100, 4);
      chk("proto_err_clean_so_far", DW'(proto_err), 0);

      // Simultaneous read and write in IDLE
      seed_r = {8{32'hC0FF_EE00}};
      bs = beats_seen;
      @(negedge clk);
      bus.avl_write_req = 1'b1; bus.avl_read_req = 1'b1; bus.avl_addr = 30'd200;
      bus.avl_size = SW'(1); bus.avl_wdata = seed_r; bus.avl_be = '1;
      chk("ready_for_collision", DW'(bus.avl_ready), 1);
      model[200] = seed_r;
      @(negedge clk);
      bus.avl_write_req = 1'b0; bus.avl_read_req = 1'b0;
      chk("proto_err_on_collision", DW'(proto_err), 1);
      chk("ready_after_collision", DW'(bus.avl_ready), 1);
      repeat (6) @(negedge clk);
      chk("ignored_read_returns_nothing", DW'(beats_seen), DW'(bs));
      sb_q.push_back(seed_r);
      read_burst(30'd200, 1);
      chk("proto_err_sticky", DW'(proto_err), 1);

      // Reset in the middle of a read's latency window
      bs = beats_seen;
      @(negedge clk);
      bus.avl_read_req = 1'b1; bus.avl_addr = 30'd200; bus.avl_size = SW'(2);
      chk("abort_read_accept_ready", DW'(bus.avl_ready), 1);
      @(negedge clk);
      bus.avl_read_req = 1'b0;
      chk("abort_ready_low", DW'(bus.avl_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_proto_err_cleared", DW'(proto_err), 0);
      chk("abort_valid_low", DW'(bus.avl_rdata_valid), 0);
      @(negedge clk);
      chk("abort_ready_in_reset", DW'(bus.avl_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_after_release", DW'(bus.avl_ready), 1);
      chk("abort_proto_err_after_release", DW'(proto_err), 0);
      repeat (6) @(negedge clk);
      chk("aborted_read_no_beats", DW'(beats_seen), DW'(bs));

      // RAM contents survive reset
      push_model(30'd200, 1);
      read_burst(30'd200, 1);
      push_model(30'd1023, 2);
      read_burst(30'd1023, 2);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", DW'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
